// File: rtl/hci_tcdm_bank_ts.sv
// Single-port TCDM bank behind the HCI log interconnect, with an optional
// test-and-set atomic (read old word, then write all-ones) enabled by HCI_BANK_TS_EN.
module hci_tcdm_bank_ts #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32,
  parameter int unsigned BW = 8,
  parameter int unsigned UW = 0,
  parameter int unsigned IW = 20
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AW-1:0]        add_i,
  input  logic                 wen_i,
  input  logic [DW/BW-1:0]     be_i,
  input  logic [DW+UW-1:0]     data_i,
  input  logic [IW-1:0]        id_i,
  input  logic                 ts_set_i,
  output logic [DW+UW-1:0]     r_data_o,
  output logic                 r_valid_o,
  output logic [IW-1:0]        r_id_o
);

  localparam int unsigned NB    = DW / BW;
  localparam int unsigned WW    = DW + UW;
  localparam int unsigned Depth = 2 ** AW;

  logic [WW-1:0] mem_q [Depth];

  logic [WW-1:0] r_data_d, r_data_q;
  logic          r_valid_d, r_valid_q;
  logic [IW-1:0] r_id_d, r_id_q;

  logic          hs;
  logic          we;
  logic [AW-1:0] waddr;
  logic [WW-1:0] wdata;
  logic [WW-1:0] wmask;
  logic [NB-1:0] wbe;

`ifdef HCI_BANK_TS_EN
  typedef enum logic {IDLE, TS_WB} state_e;
  state_e        state_d, state_q;
  logic [AW-1:0] ts_add_d, ts_add_q;
  logic [NB-1:0] ts_be_d, ts_be_q;

  assign gnt_o = (state_q == IDLE);
`else
  logic unused_ts_set;
  assign unused_ts_set = ts_set_i;
  assign gnt_o = 1'b1;
`endif

  // Byte-enable expansion; user sideband follows the OR of all byte enables.
  for (genvar i = 0; i < NB; i++) begin : g_dmask
    assign wmask[i*BW +: BW] = {BW{wbe[i]}};
  end
  if (UW > 0) begin : g_umask
    assign wmask[WW-1:DW] = {UW{|wbe}};
  end

  always_comb begin
    r_data_d  = r_data_q;
    r_valid_d = 1'b0;
    r_id_d    = r_id_q;
    hs        = req_i & gnt_o;
    we        = 1'b0;
    waddr     = add_i;
    wdata     = data_i;
    wbe       = be_i;
`ifdef HCI_BANK_TS_EN
    state_d   = state_q;
    ts_add_d  = ts_add_q;
    ts_be_d   = ts_be_q;
`endif
    if (clear_i) begin
      // Soft clear drops any granted request and any pending write-back.
      r_data_d = '0;
      r_id_d   = '0;
`ifdef HCI_BANK_TS_EN
      state_d  = IDLE;
`endif
    end
`ifdef HCI_BANK_TS_EN
    else if (state_q == TS_WB) begin
      we      = 1'b1;
      waddr   = ts_add_q;
      wdata   = '1;
      wbe     = ts_be_q;
      state_d = IDLE;
    end
`endif
    else if (hs) begin
      r_valid_d = 1'b1;
      r_id_d    = id_i;
      if (wen_i) begin
        r_data_d = mem_q[add_i];
`ifdef HCI_BANK_TS_EN
        if (ts_set_i) begin
          state_d  = TS_WB;
          ts_add_d = add_i;
          ts_be_d  = be_i;
        end
`endif
      end else begin
        we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
      r_id_q    <= '0;
`ifdef HCI_BANK_TS_EN
      state_q   <= IDLE;
      ts_add_q  <= '0;
      ts_be_q   <= '0;
`endif
    end else begin
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
      r_id_q    <= r_id_d;
`ifdef HCI_BANK_TS_EN
      state_q   <= state_d;
      ts_add_q  <= ts_add_d;
      ts_be_q   <= ts_be_d;
`endif
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we) mem_q[waddr] <= (mem_q[waddr] & ~wmask) | (wdata & wmask);
  end

  assign r_data_o  = r_data_q;
  assign r_valid_o = r_valid_q;
  assign r_id_o    = r_id_q;

endmodule

// File: tb/tb_hci_tcdm_bank_ts.sv
// Directed bench for hci_tcdm_bank_ts; test-and-set cases follow HCI_BANK_TS_EN.
module tb_hci_tcdm_bank_ts;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 8;
  localparam int unsigned UW = 0;
  localparam int unsigned IW = 20;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              clear_i;
  logic              req_i;
  logic              gnt_o;
  logic [AW-1:0]     add_i;
  logic              wen_i;
  logic [DW/BW-1:0]  be_i;
  logic [DW+UW-1:0]  data_i;
  logic [IW-1:0]     id_i;
  logic              ts_set_i;
  logic [DW+UW-1:0]  r_data_o;
  logic              r_valid_o;
  logic [IW-1:0]     r_id_o;

  int checks = 0;
  int failures = 0;

  hci_tcdm_bank_ts #(.AW(AW), .DW(DW), .BW(BW), .UW(UW), .IW(IW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .req_i(req_i), .gnt_o(gnt_o),
    .add_i(add_i), .wen_i(wen_i), .be_i(be_i), .data_i(data_i), .id_i(id_i),
    .ts_set_i(ts_set_i), .r_data_o(r_data_o), .r_valid_o(r_valid_o), .r_id_o(r_id_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic wen, input logic [AW-1:0] add, input logic [3:0] be,
                       input logic [31:0] data, input logic [IW-1:0] id, input logic ts);
    req_i = 1'b1; wen_i = wen; add_i = add; be_i = be;
    data_i = data; id_i = id; ts_set_i = ts;
  endtask

  task automatic idle();
    req_i = 1'b0; wen_i = 1'b1; ts_set_i = 1'b0; clear_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; req_i = 1'b0; add_i = '0; wen_i = 1'b1;
    be_i = '0; data_i = '0; id_i = '0; ts_set_i = 1'b0;
    #12;
    check_eq("rst_valid", 64'(r_valid_o), 64'd0);
    check_eq("rst_data", 64'(r_data_o), 64'd0);
    check_eq("rst_id", 64'(r_id_o), 64'd0);
    check_eq("rst_gnt", 64'(gnt_o), 64'd1);
    rst_ni = 1'b1;
    step();

    // Full write then read back
    drive(1'b0, 10'd5, 4'hF, 32'hDEADBEEF, 20'd3, 1'b0);
    check_eq("wr_gnt", 64'(gnt_o), 64'd1);
    step(); idle();
    check_eq("wr_valid", 64'(r_valid_o), 64'd1);
    check_eq("wr_id", 64'(r_id_o), 64'd3);
    check_eq("wr_data_hold", 64'(r_data_o), 64'd0);
    drive(1'b1, 10'd5, 4'hF, 32'h0, 20'd4, 1'b0);
    step(); idle();
    check_eq("rd5_valid", 64'(r_valid_o), 64'd1);
    check_eq("rd5_data", 64'(r_data_o), 64'hDEADBEEF);
    check_eq("rd5_id", 64'(r_id_o), 64'd4);
    step();
    check_eq("idle_valid", 64'(r_valid_o), 64'd0);

    // Partial write, then read the same address in the very next cycle
    drive(1'b0, 10'd5, 4'b0101, 32'h11223344, 20'd5, 1'b0);
    step();
    check_eq("pwr_valid", 64'(r_valid_o), 64'd1);
    check_eq("pwr_id", 64'(r_id_o), 64'd5);
    drive(1'b1, 10'd5, 4'hF, 32'h0, 20'd6, 1'b0);
    step(); idle();
    check_eq("prd_data", 64'(r_data_o), 64'hDE22BE44);
    check_eq("prd_id", 64'(r_id_o), 64'd6);

    // Seed addresses 7 and 9
    drive(1'b0, 10'd7, 4'hF, 32'h0, 20'd7, 1'b0);
    step();
    drive(1'b0, 10'd9, 4'hF, 32'hA5A50009, 20'd8, 1'b0);
    step(); idle();

    // Test-and-set on addr 7 with a read of addr 9 held behind it
    drive(1'b1, 10'd7, 4'hF, 32'h0, 20'd9, 1'b1);
    step();
    check_eq("ts_valid", 64'(r_valid_o), 64'd1);
    check_eq("ts_old", 64'(r_data_o), 64'd0);
    check_eq("ts_id", 64'(r_id_o), 64'd9);
    drive(1'b1, 10'd9, 4'hF, 32'h0, 20'd10, 1'b0);
`ifdef HCI_BANK_TS_EN
    check_eq("tswb_gnt", 64'(gnt_o), 64'd0);
    step();
    check_eq("tswb_valid", 64'(r_valid_o), 64'd0);
    check_eq("after_wb_gnt", 64'(gnt_o), 64'd1);
`else
    check_eq("nots_gnt", 64'(gnt_o), 64'd1);
`endif
    step(); idle();
    check_eq("held_valid", 64'(r_valid_o), 64'd1);
    check_eq("held_data", 64'(r_data_o), 64'hA5A50009);
    check_eq("held_id", 64'(r_id_o), 64'd10);
    drive(1'b1, 10'd7, 4'hF, 32'h0, 20'd11, 1'b0);
    step(); idle();
`ifdef HCI_BANK_TS_EN
    check_eq("ts_set_data", 64'(r_data_o), 64'hFFFFFFFF);
`else
    check_eq("ts_ign_data", 64'(r_data_o), 64'd0);
`endif

    // Clear during the write-back aborts it
    drive(1'b0, 10'd7, 4'hF, 32'h12345678, 20'd12, 1'b0);
    step();
    drive(1'b1, 10'd7, 4'hF, 32'h0, 20'd13, 1'b1);
    step(); idle();
    check_eq("ts2_old", 64'(r_data_o), 64'h12345678);
    clear_i = 1'b1;
    step(); idle();
    check_eq("clr_valid", 64'(r_valid_o), 64'd0);
    check_eq("clr_id", 64'(r_id_o), 64'd0);
    check_eq("clr_data", 64'(r_data_o), 64'd0);
    drive(1'b1, 10'd7, 4'hF, 32'h0, 20'd14, 1'b0);
    step(); idle();
    check_eq("clr_keep", 64'(r_data_o), 64'h12345678);

    // A request presented together with clear is swallowed
    drive(1'b0, 10'd7, 4'hF, 32'hFFFF0000, 20'd15, 1'b0);
    clear_i = 1'b1;
    check_eq("clrreq_gnt", 64'(gnt_o), 64'd1);
    step(); idle();
    check_eq("clrreq_valid", 64'(r_valid_o), 64'd0);
    drive(1'b1, 10'd7, 4'hF, 32'h0, 20'd16, 1'b0);
    step(); idle();
    check_eq("clrreq_keep", 64'(r_data_o), 64'h12345678);

    // Back-to-back writes then reads of addrs 1..3
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 10'(i), 4'hF, 32'h0000_0100 + 32'(i), 20'(i), 1'b0);
      step();
    end
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 10'(i), 4'hF, 32'h0, 20'(20 + i), 1'b0);
      step();
      check_eq("b2b_valid", 64'(r_valid_o), 64'd1);
      check_eq("b2b_data", 64'(r_data_o), 64'h0000_0100 + 64'(i));
      check_eq("b2b_id", 64'(r_id_o), 64'(20 + i));
    end
    idle();
    step();
    check_eq("end_valid", 64'(r_valid_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
